// File: rtl/morse_pkg.sv
// Shared constants and FSM state type for the Morse decoder.
// Holds the ASCII codes emitted for spaces and undecodable characters.
package morse_pkg;

  localparam logic [7:0] ASCII_SPACE     = 8'h20;
  localparam logic [7:0] ASCII_QMARK     = 8'h3F;
  localparam int         MAX_SYM_DEFAULT = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MARK,
    ST_GAP
  } state_t;

endpackage

// File: rtl/morse_decoder_if.sv
// Decoded-character bus: one-cycle valid pulse, payload fields hold between pulses.
// No ready path: the consumer must accept every pulse.
interface morse_decoder_if;

  logic [7:0] char_out;
  logic       char_valid;
  logic [7:0] pattern_out;
  logic [2:0] length_out;
  logic       err;

  modport master (
    output char_out,
    output char_valid,
    output pattern_out,
    output length_out,
    output err
  );

  modport slave (
    input char_out,
    input char_valid,
    input pattern_out,
    input length_out,
    input err
  );

endinterface

// File: rtl/morse_lut.sv
// Combinational ITU Morse table for A-Z and 0-9; bit i = symbol i, 1 = dash.
// Zero latency, no flow control.
module morse_lut
  import morse_pkg::*;
(
  input  logic [7:0] pattern,
  input  logic [2:0] length,
  output logic [7:0] ascii,
  output logic       valid
);

  logic [7:0] key;

  assign key = {length, pattern[4:0]};

  always_comb begin
    ascii = ASCII_QMARK;
    valid = 1'b1;
    case (key)
      {3'd2, 5'd2}:  ascii = "A";
      {3'd4, 5'd1}:  ascii = "B";
      {3'd4, 5'd5}:  ascii = "C";
      {3'd3, 5'd1}:  ascii = "D";
      {3'd1, 5'd0}:  ascii = "E";
      {3'd4, 5'd4}:  ascii = "F";
      {3'd3, 5'd3}:  ascii = "G";
      {3'd4, 5'd0}:  ascii = "H";
      {3'd2, 5'd0}:  ascii = "I";
      {3'd4, 5'd14}: ascii = "J";
      {3'd3, 5'd5}:  ascii = "K";
      {3'd4, 5'd2}:  ascii = "L";
      {3'd2, 5'd3}:  ascii = "M";
      {3'd2, 5'd1}:  ascii = "N";
      {3'd3, 5'd7}:  ascii = "O";
      {3'd4, 5'd6}:  ascii = "P";
      {3'd4, 5'd11}: ascii = "Q";
      {3'd3, 5'd2}:  ascii = "R";
      {3'd3, 5'd0}:  ascii = "S";
      {3'd1, 5'd1}:  ascii = "T";
      {3'd3, 5'd4}:  ascii = "U";
      {3'd4, 5'd8}:  ascii = "V";
      {3'd3, 5'd6}:  ascii = "W";
      {3'd4, 5'd9}:  ascii = "X";
      {3'd4, 5'd13}: ascii = "Y";
      {3'd4, 5'd3}:  ascii = "Z";
      {3'd5, 5'd31}: ascii = "0";
      {3'd5, 5'd30}: ascii = "1";
      {3'd5, 5'd28}: ascii = "2";
      {3'd5, 5'd24}: ascii = "3";
      {3'd5, 5'd16}: ascii = "4";
      {3'd5, 5'd0}:  ascii = "5";
      {3'd5, 5'd1}:  ascii = "6";
      {3'd5, 5'd3}:  ascii = "7";
      {3'd5, 5'd7}:  ascii = "8";
      {3'd5, 5'd15}: ascii = "9";
      default:       valid = 1'b0;
    endcase
    // Symbols beyond the fifth never form a valid character.
    if (pattern[7:5] != 3'b000) valid = 1'b0;
  end

endmodule

// File: rtl/morse_decoder.sv
// Morse key decoder: times marks/gaps in dot units and emits ASCII; word space gated by MORSE_DEC_WORD_SPACE_EN.
// Latency: char_valid 1 cycle after the gap reaches 2 units (space at 5 units); no backpressure, pulses are fire-and-forget.
module morse_decoder
  import morse_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int MAX_SYM = MAX_SYM_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_in,
  input  logic [CNT_W-1:0] unit_ticks,
  morse_decoder_if.master  dec
);

  localparam logic [2:0] MAX_LEN = 3'(MAX_SYM);

  state_t           state;
  logic             key_q1;
  logic             key_s;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [7:0]       sym_buf;
  logic [2:0]       sym_cnt;
  logic             ovf;

  logic [7:0]       char_q;
  logic             valid_q;
  logic [7:0]       pattern_q;
  logic [2:0]       length_q;
  logic             err_q;

  logic [CNT_W+2:0] unit_w;
  logic [CNT_W+2:0] thr2;
  logic [CNT_W+2:0] cnt_w;
  logic             is_dash;
  logic             char_end;
  logic [7:0]       lut_ascii;
  logic             lut_valid;

  // Thresholds are computed three bits wider so 5*unit never overflows.
  assign unit_w  = (unit_ticks == '0) ? {{(CNT_W+2){1'b0}}, 1'b1} : {3'b000, unit_ticks};
  assign thr2    = unit_w << 1;
  assign cnt_w   = {3'b000, cnt};
  assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);
  assign is_dash = (cnt_w >= thr2);

`ifdef MORSE_DEC_WORD_SPACE_EN
  logic             emitted;
  logic [CNT_W+2:0] thr5;

  assign thr5     = (unit_w << 2) + unit_w;
  assign char_end = (state == ST_GAP) && !emitted && (cnt_w >= thr2);
`else
  assign char_end = (state == ST_GAP) && (cnt_w >= thr2);
`endif

  morse_lut u_lut (
    .pattern (sym_buf),
    .length  (sym_cnt),
    .ascii   (lut_ascii),
    .valid   (lut_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      key_q1    <= 1'b0;
      key_s     <= 1'b0;
      cnt       <= '0;
      sym_buf   <= '0;
      sym_cnt   <= '0;
      ovf       <= 1'b0;
      char_q    <= 8'h00;
      valid_q   <= 1'b0;
      pattern_q <= 8'h00;
      length_q  <= 3'd0;
      err_q     <= 1'b0;
`ifdef MORSE_DEC_WORD_SPACE_EN
      emitted   <= 1'b0;
`endif
    end else begin
      key_q1  <= key_in;
      key_s   <= key_q1;
      valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (key_s) begin
            state <= ST_MARK;
            cnt   <= CNT_W'(1);
          end
        end
        ST_MARK: begin
          if (key_s) begin
            cnt <= cnt_inc;
          end else begin
            // Marks past the symbol limit are dropped but poison the character.
            if (sym_cnt < MAX_LEN) begin
              sym_buf[sym_cnt] <= is_dash;
              sym_cnt          <= sym_cnt + 3'd1;
            end else begin
              ovf <= 1'b1;
            end
            state <= ST_GAP;
            cnt   <= CNT_W'(1);
          end
        end
        ST_GAP: begin
          cnt <= cnt_inc;
          if (char_end) begin
            valid_q   <= 1'b1;
            pattern_q <= sym_buf;
            length_q  <= sym_cnt;
            if (ovf || !lut_valid) begin
              char_q <= ASCII_QMARK;
              err_q  <= 1'b1;
            end else begin
              char_q <= lut_ascii;
              err_q  <= 1'b0;
            end
            sym_buf <= '0;
            sym_cnt <= '0;
            ovf     <= 1'b0;
`ifdef MORSE_DEC_WORD_SPACE_EN
            emitted <= 1'b1;
          end else if (emitted && (cnt_w >= thr5)) begin
            valid_q   <= 1'b1;
            char_q    <= ASCII_SPACE;
            pattern_q <= 8'h00;
            length_q  <= 3'd0;
            err_q     <= 1'b0;
            emitted   <= 1'b0;
            state     <= ST_IDLE;
`else
            state   <= ST_IDLE;
`endif
          end
          // A rise on the ending cycle still starts a fresh character.
          if (key_s) begin
            state <= ST_MARK;
            cnt   <= CNT_W'(1);
`ifdef MORSE_DEC_WORD_SPACE_EN
            emitted <= 1'b0;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dec.char_out    = char_q;
  assign dec.char_valid  = valid_q;
  assign dec.pattern_out = pattern_q;
  assign dec.length_out  = length_q;
  assign dec.err         = err_q;

endmodule

// File: doc/morse_decoder.md
MORSE_DECODER -- requirements
Module: morse_decoder

Interface
REQ-001 Parameter CNT_W, default 16: width of unit_ticks and of the duration counter.
REQ-002 Parameter MAX_SYM, default 6: maximum number of symbols in one character.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port key_in, input, 1: raw key level, 1 = mark (tone on); asynchronous to clk.
REQ-006 Port unit_ticks, input, CNT_W: dot length in clk cycles; treated as static while a character is in progress.
REQ-007 Port char_out, output, 8: last decoded ASCII character.
REQ-008 Port char_valid, output, 1: one-cycle pulse when char_out is updated.
REQ-009 Port pattern_out, output, 8: symbol pattern of the last character; bit i = symbol i, first symbol in bit 0, 1 = dash; unused bits 0.
REQ-010 Port length_out, output, 3: symbol count of the last character.
REQ-011 Port err, output, 1: set together with char_valid when the character was undecodable or overflowed; cleared at the next char_valid.

Function
REQ-012 key_in SHALL pass through a 2-flop synchronizer; key_s denotes its output, and all timing below is in key_s cycles.
REQ-013 A unit_ticks value of 0 SHALL be treated as 1.
REQ-014 The FSM SHALL have states IDLE, MARK and GAP.
- IDLE: key_s rise -> MARK, counter = 1.
- MARK: counter increments; on key_s fall, append a symbol and go to GAP with counter = 1.
- GAP: counter increments; key_s rise -> MARK.
REQ-015 A mark of count >= 2*unit_ticks SHALL be a dash; any shorter mark SHALL be a dot (e.g. unit_ticks=4: 7 is a dot, 8 is a dash).
REQ-016 In GAP, the cycle the counter reaches 2*unit_ticks SHALL end the character: the registered outputs update and char_valid pulses on the next edge (latency 1 cycle).
REQ-017 If key_s rises on the same cycle the character ends, the character SHALL still be emitted and the new mark SHALL start a fresh character.
REQ-018 The duration counter SHALL saturate at all-ones and never wrap; threshold comparisons SHALL use CNT_W+3 bits.
REQ-019 Decode SHALL cover A-Z (uppercase) and 0-9 per ITU Morse; any other pattern SHALL give 0x3F ('?') with err=1.
REQ-020 A mark beyond MAX_SYM symbols SHALL set an overflow flag and be discarded; the character SHALL then emit 0x3F with err=1 and length_out=MAX_SYM.
REQ-021 After a character ends with no further mark, the FSM SHALL return to IDLE once word-space handling (REQ-026) completes.
REQ-022 char_out, pattern_out, length_out and err SHALL hold between pulses.

Reset
REQ-023 Reset SHALL force: state IDLE, counter 0, symbol buffer and overflow flag cleared, synchronizer flops 0, char_out 0x00, char_valid 0, pattern_out 0, length_out 0, err 0.
REQ-024 Reset asserted mid-character SHALL discard the partial character without any char_valid pulse.
REQ-025 After reset release, a key_in already high SHALL be treated as a new mark.

Configuration
REQ-026 Macro MORSE_DEC_WORD_SPACE_EN:
- Defined: in GAP after a character has been emitted, the cycle the counter reaches 5*unit_ticks SHALL emit char_out 0x20 with char_valid, length_out 0 and err 0, exactly once per gap, then go to IDLE.
- Undefined: no space is emitted, and the FSM goes to IDLE immediately after the character emission.

Structure
REQ-027 Package morse_pkg SHALL hold the ASCII constants (0x20, 0x3F), the FSM state enum, and the default MAX_SYM.
REQ-028 A combinational sub-module morse_lut (inputs pattern and length; outputs ascii and valid) SHALL hold the decode table.

Verification
REQ-029 unit_ticks=4; key high 4, low 12 -> char_out 0x45 ('E'), length_out 1, pattern_out 0x00, err 0.
REQ-030 unit_ticks=4; high 4, low 4, high 12, low 8 -> 0x41 ('A'), pattern_out 0x02, length_out 2.
REQ-031 unit_ticks=4; mark of 7 vs mark of 8, each followed by low 8 -> 0x45 ('E') then 0x54 ('T').
REQ-032 unit_ticks=4; 7 dots separated by low 4 -> 0x3F, err 1, length_out 6.
REQ-033 unit_ticks=4; 'E' then low 20 -> 0x45 then 0x20 (macro defined) or 0x45 only (macro undefined).
REQ-034 Reset pulse after 2 marks of a character -> no char_valid; all outputs at their reset values.
